sha256_core_p: RTL and testbench

Parametrised SHA-256 compression engine and the successor to the fixed two-rounds-per-cycle hasher. It computes `UNROLL` rounds per clock and keeps a 16-word sliding message schedule instead of a 64-word array. It chains the intermediate hash across any number of pre-padded 512-bit blocks and accepts blocks through a valid/ready handshake. It sits between the padding/block-feed logic and the digest consumer.

---
 rtl/sha256_pkg.sv | 53 +++++
 rtl/sha256_round.sv | 18 +
 rtl/sha256_core_p.sv | 119 +++++++++++
 tb/tb_sha256_core_p.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// sha256_pkg: SHA-256 constants, round helper functions and engine state type.
package sha256_pkg;

    typedef enum logic [1:0] {IDLE, ROUND, FINAL} sha_state_t;

    // Eight 32-bit words; index 0 is a/H0 and sits in the most significant slot.
    typedef logic [0:7][31:0] sha_vars_t;

    localparam sha_vars_t IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f, input logic [31:0] g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

endpackage

// File: rtl/sha256_round.sv
// sha256_round: one combinational SHA-256 compression round.
module sha256_round
    import sha256_pkg::*;
(
    input  sha_vars_t   s_i,
    input  logic [31:0] w_i,
    input  logic [31:0] k_i,
    output sha_vars_t   s_o
);

    logic [31:0] w_t1;
    logic [31:0] w_t2;

    assign w_t1 = s_i[7] + bsig1(s_i[4]) + ch(s_i[4], s_i[5], s_i[6]) + k_i + w_i;
    assign w_t2 = bsig0(s_i[0]) + maj(s_i[0], s_i[1], s_i[2]);
    assign s_o  = {w_t1 + w_t2, s_i[0], s_i[1], s_i[2], s_i[3] + w_t1, s_i[4], s_i[5], s_i[6]};

endmodule

// File: rtl/sha256_core_p.sv
// sha256_core_p: SHA-256 compression engine running UNROLL rounds per clock with block chaining.
module sha256_core_p
    import sha256_pkg::*;
#(
    parameter int UNROLL = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [511:0] blk_i,
    input  logic         first_i,
    input  logic         last_i,
    input  logic         blk_valid_i,
    output logic         blk_ready_o,
    output logic         busy_o,
    output logic [255:0] digest_o,
    output logic         digest_valid_o
);

    localparam logic [5:0] LAST_CNT = 6'(64 - UNROLL);

    if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4 && UNROLL != 8) begin : g_bad_unroll
        $error("sha256_core_p: UNROLL must be 1, 2, 4 or 8");
    end

    sha_state_t  r_state;
    sha_state_t  w_next;
    logic [5:0]  r_cnt;
    logic [31:0] r_w [0:15];
    logic [31:0] w_ext [0:15+UNROLL];
    sha_vars_t   r_wk;
    sha_vars_t   r_h;
    sha_vars_t   w_hnew;
    sha_vars_t   r_digest;
    logic        r_first;
    logic        r_last;
    logic        r_dvalid;

    assign blk_ready_o    = (r_state == IDLE);
    assign busy_o         = !blk_ready_o;
    assign digest_o       = r_digest;
    assign digest_valid_o = r_dvalid;

    // Chain of UNROLL rounds; round i of this cycle uses window word i.
    for (genvar i = 0; i < UNROLL; i++) begin : g_rnd
        sha_vars_t w_in;
        sha_vars_t w_out;
        if (i == 0) begin : g_head
            assign w_in = r_wk;
        end else begin : g_link
            assign w_in = g_rnd[i-1].w_out;
        end
        sha256_round u_round (
            .s_i (w_in),
            .w_i (r_w[i]),
            .k_i (K[r_cnt + 6'(i)]),
            .s_o (w_out)
        );
    end

    // Extend the window by UNROLL words; later words feed on earlier new ones.
    always_comb begin
        for (int i = 0; i < 16; i++) w_ext[i] = r_w[i];
        for (int i = 16; i < 16 + UNROLL; i++) w_ext[i] = ssig1(w_ext[i-2]) + w_ext[i-7] + ssig0(w_ext[i-15]) + w_ext[i-16];
    end

    // Feed-forward: chain base is the IV for the first block of a message, else the running hash.
    always_comb begin
        w_hnew = '0;
        for (int i = 0; i < 8; i++) w_hnew[i] = (r_first ? IV[i] : r_h[i]) + r_wk[i];
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Next-state: accept in IDLE, leave ROUND on its last cycle, FINAL always returns to IDLE.
    always_comb begin
        w_next = r_state;
        w_next = (r_state == IDLE && blk_valid_i)       ? ROUND :
                 (r_state == ROUND && r_cnt == LAST_CNT) ? FINAL :
                 (r_state == FINAL)                      ? IDLE  : r_state;
    end

    // Datapath: block load, round/schedule advance, chain update and digest publication.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) r_w[i] <= '0;
            r_cnt    <= '0;
            r_wk     <= '0;
            r_h      <= IV;
            r_first  <= 1'b0;
            r_last   <= 1'b0;
            r_digest <= '0;
            r_dvalid <= 1'b0;
        end else begin
            r_dvalid <= 1'b0;
            if (r_state == IDLE && blk_valid_i) begin
                for (int i = 0; i < 16; i++) r_w[i] <= blk_i[511 - 32*i -: 32];
                r_cnt   <= '0;
                r_wk    <= first_i ? IV : r_h;
                r_first <= first_i;
                r_last  <= last_i;
            end else if (r_state == ROUND) begin
                for (int i = 0; i < 16; i++) r_w[i] <= w_ext[i + UNROLL];
                r_cnt <= r_cnt + 6'(UNROLL);
                r_wk  <= g_rnd[UNROLL-1].w_out;
            end else if (r_state == FINAL) begin
                r_h <= w_hnew;
                if (r_last) begin
                    r_digest <= w_hnew;
                    r_dvalid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sha256_core_p.sv
// tb_sha256_core_p: directed scoreboard bench over UNROLL = 1, 2, 4, 8 instances.
module tb_sha256_core_p;

    localparam logic [511:0] ABC   = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] EMPTY = {32'h80000000, 480'h0};
    localparam logic [511:0] B1    = {448'h6162636462636465636465666465666765666768666768696768696a68696a6b696a6b6c6a6b6c6d6b6c6d6e6c6d6e6f6d6e6f706e6f7071, 32'h80000000, 32'h0};
    localparam logic [511:0] B2    = {480'h0, 32'h000001c0};
    localparam logic [255:0] D_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] D_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] D_TWO   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    typedef struct {
        int           u;
        logic [255:0] d;
        int           c;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [511:0] blk = '0;
    logic         fst = 1'b0;
    logic         lst = 1'b0;
    logic         vld [4];
    logic         rdy [4];
    logic         bsy [4];
    logic         dv  [4];
    logic [255:0] dg  [4];
    int           cyc = 0;
    int           checks = 0;
    int           fails = 0;
    exp_t         sb [$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        sha256_core_p #(.UNROLL(1 << g)) u_dut (
            .clk            (clk),
            .rst            (rst),
            .blk_i          (blk),
            .first_i        (fst),
            .last_i         (lst),
            .blk_valid_i    (vld[g]),
            .blk_ready_o    (rdy[g]),
            .busy_o         (bsy[g]),
            .digest_o       (dg[g]),
            .digest_valid_o (dv[g])
        );
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive a block to instance u; optionally scramble inputs while the engine is busy.
    task automatic send(input int u, input logic [511:0] b, input logic f, input logic l, input logic pub,
                        input logic hold, input logic noisy, input logic [255:0] exp,
                        output int e0, output int lows);
        bit got = 0;
        lows = 0;
        e0 = -1;
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clk);
            vld[u] = 1'b1;
            if (rdy[u]) begin
                blk = b;
                fst = f;
                lst = l;
                got = 1;
            end else begin
                lows++;
                if (noisy) begin
                    for (int j = 0; j < 16; j++) blk[j*32 +: 32] = $urandom;
                    fst = 1'($urandom);
                    lst = 1'($urandom);
                end
            end
        end
        if (!got) begin
            check($sformatf("handshake_timeout_u%0d", u), 256'(got), 256'd1);
            vld[u] = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        e0 = cyc;
        if (!hold) vld[u] = 1'b0;
        if (l && pub) sb.push_back('{u, exp, e0 + (64 >> u) + 1});
    endtask

    task automatic drain(input int u);
        for (int k = 0; k < 300 && sb.size() != 0; k++) @(negedge clk);
        check($sformatf("drain_u%0d", u), 256'(sb.size()), 256'd0);
        repeat (3) @(negedge clk);
    endtask

    // Scoreboard monitor: every digest pulse must match the oldest expected entry.
    always @(negedge clk) begin
        for (int u = 0; u < 4; u++) begin
            if (dv[u] === 1'b1) begin
                if (sb.size() == 0) begin
                    check($sformatf("unexpected_pulse_u%0d", u), 256'(dv[u]), 256'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check($sformatf("pulse_unit_u%0d", u), 256'(u), 256'(e.u));
                    check($sformatf("digest_u%0d", u), dg[u], e.d);
                    check($sformatf("latency_u%0d", u), 256'(cyc), 256'(e.c));
                    check($sformatf("ready_with_pulse_u%0d", u), 256'(rdy[u]), 256'd1);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int e0, e0a, e0b, lows, r;
        for (int u = 0; u < 4; u++) vld[u] = 1'b0;
        #12;
        for (int u = 0; u < 4; u++) begin
            check($sformatf("reset_ready_u%0d", u), 256'(rdy[u]), 256'd1);
            check($sformatf("reset_busy_u%0d", u), 256'(bsy[u]), 256'd0);
            check($sformatf("reset_dvalid_u%0d", u), 256'(dv[u]), 256'd0);
            check($sformatf("reset_digest_u%0d", u), dg[u], 256'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int u = 0; u < 4; u++) begin
            r = 64 >> u;
            send(u, ABC, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, D_ABC, e0, lows);
            check($sformatf("busy_in_round_u%0d", u), 256'(bsy[u]), 256'd1);
            check($sformatf("ready_in_round_u%0d", u), 256'(rdy[u]), 256'd0);
            drain(u);
            check($sformatf("digest_hold_abc_u%0d", u), dg[u], D_ABC);
            send(u, EMPTY, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, D_EMPTY, e0, lows);
            drain(u);
            send(u, B1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, '0, e0a, lows);
            send(u, B2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, D_TWO, e0b, lows);
            check($sformatf("b2b_period_u%0d", u), 256'(e0b - e0a), 256'(r + 2));
            check($sformatf("ready_low_cycles_u%0d", u), 256'(lows), 256'(r + 1));
            check($sformatf("intermediate_untouched_u%0d", u), dg[u], D_EMPTY);
            drain(u);
            send(u, ABC, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, D_ABC, e0, lows);
            repeat (20 >> u) @(negedge clk);
            rst = 1'b1;
            #1;
            check($sformatf("abort_ready_u%0d", u), 256'(rdy[u]), 256'd1);
            check($sformatf("abort_busy_u%0d", u), 256'(bsy[u]), 256'd0);
            check($sformatf("abort_dvalid_u%0d", u), 256'(dv[u]), 256'd0);
            check($sformatf("abort_digest_u%0d", u), dg[u], 256'd0);
            @(negedge clk);
            rst = 1'b0;
            send(u, ABC, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, D_ABC, e0, lows);
            drain(u);
            repeat (5) @(negedge clk);
            check($sformatf("digest_hold_final_u%0d", u), dg[u], D_ABC);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
